// File: rtl/conv2_fmap_collector_pkg.sv
// Shared types and helpers for the Conv_layer2 fmap collector.
// Holds the FSM state encoding and a constant-foldable clog2.
package conv2_fmap_collector_pkg;

    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_DONE    = 1'b1
    } state_t;

    function automatic int clog2(input int value);
        int res;
        int rem;
        res = 0;
        rem = value - 1;
        while (rem > 0) begin
            res = res + 1;
            rem = rem >> 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/conv2_fmap_collector_sp_bram.sv
// Single-port buffer RAM, read-first, 1-cycle registered read when en is high.
// Latency: 1 cycle. Backpressure: none, one access per cycle.
// Contents are intentionally not reset.
module conv2_fmap_collector_sp_bram #(
    parameter int DEPTH = 192,
    parameter int DW    = 16,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= din;
            end
            dout <= mem[addr];
        end
    end

endmodule

// File: rtl/conv2_fmap_collector.sv
// Collects the pooled Conv_layer2 fmap channel-major, then serves it on a read port.
// Latency: read data 1 cycle after i_rd_en. Backpressure: none; framing errors are sticky flags.
// Writes happen only while collecting, so the single RAM port is shared with reads.
module conv2_fmap_collector
    import conv2_fmap_collector_pkg::*;
#(
    parameter int O_BW   = 16,
    parameter int O_SIZE = 4,
    parameter int CO     = 12,
    localparam int PIX_N   = O_SIZE * O_SIZE,
    localparam int DEPTH   = CO * PIX_N,
    localparam int ADDR_BW = clog2(DEPTH),
    localparam int CH_BW   = clog2(CO) + 1
) (
    input  logic               clk,
    input  logic               user_reset,
    input  logic [O_BW-1:0]    i_data,
    input  logic               i_valid,
    input  logic               i_ch_end,
    input  logic               i_allch_end,
    input  logic               i_restart,
    input  logic               i_rd_en,
    input  logic [ADDR_BW-1:0] i_rd_addr,
    output logic [O_BW-1:0]    o_rd_data,
    output logic               o_rd_valid,
    output logic               o_done,
    output logic [CH_BW-1:0]   o_ch_cnt,
    output logic               o_err_ovf,
    output logic               o_err_short
);

    localparam int PIX_BW = clog2(PIX_N) + 1;
    localparam logic [PIX_BW-1:0] PIX_FULL = PIX_BW'(PIX_N);
    localparam logic [CH_BW-1:0]  CH_FULL  = CH_BW'(CO);
    localparam logic [ADDR_BW:0]  ADDR_LIM = (ADDR_BW + 1)'(DEPTH);

    state_t            state, state_nxt;
    logic [CH_BW-1:0]  ch, ch_nxt, ch_after;
    logic [PIX_BW-1:0] pix, pix_nxt, pix_after;
    logic              err_ovf, err_ovf_nxt;
    logic              err_short, err_short_nxt;
    logic              wr_en;
    logic              rd_hit, rd_hit_q;
    logic              rd_vld_q;
    logic [ADDR_BW-1:0] wr_addr, bram_addr;
    logic [O_BW-1:0]   bram_dout;

    always_ff @(posedge clk) begin
        if (user_reset) begin
            state     <= ST_COLLECT;
            ch        <= '0;
            pix       <= '0;
            err_ovf   <= 1'b0;
            err_short <= 1'b0;
            rd_vld_q  <= 1'b0;
            rd_hit_q  <= 1'b0;
        end else begin
            state     <= state_nxt;
            ch        <= ch_nxt;
            pix       <= pix_nxt;
            err_ovf   <= err_ovf_nxt;
            err_short <= err_short_nxt;
            rd_vld_q  <= i_rd_en;
            rd_hit_q  <= rd_hit;
        end
    end

    // Same-cycle valid is counted before ch_end, and ch_end before allch_end.
    always_comb begin
        state_nxt     = state;
        ch_nxt        = ch;
        pix_nxt       = pix;
        err_ovf_nxt   = err_ovf;
        err_short_nxt = err_short;
        wr_en         = 1'b0;
        pix_after     = pix;
        ch_after      = ch;
        if (i_restart) begin
            state_nxt     = ST_COLLECT;
            ch_nxt        = '0;
            pix_nxt       = '0;
            err_ovf_nxt   = 1'b0;
            err_short_nxt = 1'b0;
        end else if (state == ST_COLLECT) begin
            if (i_valid) begin
                if (pix < PIX_FULL) begin
                    wr_en     = 1'b1;
                    pix_after = pix + 1'b1;
                end else begin
                    err_ovf_nxt = 1'b1;
                end
            end
            pix_nxt = pix_after;
            if (i_ch_end) begin
                if (pix_after != PIX_FULL) begin
                    err_short_nxt = 1'b1;
                end
                pix_nxt = '0;
                if (ch < CH_FULL) begin
                    ch_after = ch + 1'b1;
                end
            end
            ch_nxt = ch_after;
            if (ch_after == CH_FULL) begin
                state_nxt = ST_DONE;
            end else if (i_allch_end) begin
                err_short_nxt = 1'b1;
                state_nxt     = ST_DONE;
            end
        end
    end

    assign wr_addr   = ADDR_BW'(ch) * ADDR_BW'(PIX_N) + ADDR_BW'(pix);
    assign rd_hit    = (state == ST_DONE) && i_rd_en && ({1'b0, i_rd_addr} < ADDR_LIM);
    assign bram_addr = (state == ST_DONE) ? i_rd_addr : wr_addr;

    conv2_fmap_collector_sp_bram #(
        .DEPTH (DEPTH),
        .DW    (O_BW),
        .AW    (ADDR_BW)
    ) u_bram (
        .clk  (clk),
        .en   (wr_en | rd_hit),
        .we   (wr_en),
        .addr (bram_addr),
        .din  (i_data),
        .dout (bram_dout)
    );

    assign o_rd_data   = rd_hit_q ? bram_dout : '0;
    assign o_rd_valid  = rd_vld_q;
    assign o_done      = (state == ST_DONE);
    assign o_ch_cnt    = ch;
    assign o_err_ovf   = err_ovf;
    assign o_err_short = err_short;

endmodule
